imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles m_req is held without m_ready before the transaction aborts (range 2..255).
REQ-002 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  in  1  fetch request; held high until if_ack.
REQ-005 SHALL have port if_addr  in  32  fetch address (next PC).
REQ-006 SHALL have port if_flush  in  1  cancels the outstanding or presented fetch (branch redirect).
REQ-007 SHALL have port if_ack, if_err  out  1 each  fetch completion pulse and fetch error flag.
REQ-008 SHALL have port if_rdata  out  32  instruction word.
REQ-009 SHALL have port d_req, d_we  in  1 each  data request and write-enable.
REQ-010 SHALL have port d_size  in  2  access size: 00 byte, 01 half, 10 word.
REQ-011 SHALL have port d_addr, d_wdata  in  32 each  data address and store data.
REQ-012 SHALL have port d_ack, d_err  out  1 each  data completion pulse and data error flag.
REQ-013 SHALL have port d_rdata  out  32  load data.
REQ-014 SHALL have port m_req, m_we  out  1 each  memory request and write-enable.
REQ-015 SHALL have port m_size  out  2  memory access size.
REQ-016 SHALL have port m_addr, m_wdata  out  32 each  memory address and write data.
REQ-017 SHALL have port m_ready  in  1  memory completion, valid only while m_req=1.
REQ-018 SHALL have port m_rdata  in  32  memory read data, valid when m_ready=1.

Function
REQ-019 SHALL implement the FSM states IDLE, I_BUSY, D_BUSY; all outputs SHALL be registered.
REQ-020 In IDLE, SHALL grant: only if_req (with if_flush=0) -> I_BUSY; only d_req -> D_BUSY; both -> the side not granted last (last_grant), then update last_grant.
REQ-021 On grant, SHALL latch m_addr, m_we, m_size and m_wdata, and set m_req=1 from the next cycle; fetch grants SHALL drive m_we=0, m_size=10, m_wdata=0.
REQ-022 SHALL hold m_* outputs stable while m_req=1 until m_ready=1 is sampled.
REQ-023 On m_ready=1, SHALL in the next cycle pulse the owner's ack for exactly one cycle, drive the owner's rdata=m_rdata (0 for writes) and err=0, drop m_req, and enter IDLE.
REQ-024 Minimum latency from req sampled to ack SHALL be 2 cycles (m_ready in the first m_req cycle).
REQ-025 rdata SHALL hold its value until that requester's next ack.
REQ-026 A req still high in the cycle its ack is high SHALL be treated as a new request.
REQ-027 Each busy state SHALL run an 8-bit wait counter, cleared on grant and incremented each m_req cycle without m_ready.
REQ-028 When the wait counter reaches TIMEOUT, SHALL drop m_req, pulse the owner's ack with err=1 and rdata=0, and enter IDLE.
REQ-029 m_ready arriving in the same cycle as the timeout condition SHALL take precedence: normal completion, err=0.
REQ-030 if_flush in IDLE SHALL suppress the fetch grant that cycle; a simultaneous d_req SHALL still be granted.
REQ-031 if_flush in I_BUSY SHALL set a kill flag; the memory transaction SHALL complete or time out normally, but no if_ack and no if_rdata update SHALL occur.
REQ-032 The kill flag SHALL clear on return to IDLE; if_flush in D_BUSY SHALL have no effect.
REQ-033 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-034 While rst=0, SHALL force state IDLE, all outputs 0, wait counter 0, kill flag 0, and last_grant=data (the first tie goes to fetch), asynchronously.
REQ-035 Reset asserted mid-transaction SHALL abandon it with no ack; after release, the first grant SHALL take at least one cycle.

Verification
REQ-036 Fetch-only: if_req=1, if_addr=0x100, m_ready=1 in the first m_req cycle, m_rdata=0xDEADBEEF -> m_addr=0x100, m_size=10; if_ack 2 cycles after the request with if_rdata=0xDEADBEEF.
REQ-037 Contention after reset: if_req and d_req rise together (d_addr=0x2000, d_we=1, d_wdata=0x55) with both held -> fetch served first, then data (m_we=1, m_wdata=0x55), then fetch, alternating.
REQ-038 Timeout: d_req with m_ready held 0, TIMEOUT=16 -> m_req high exactly 16 cycles, d_ack=1 with d_err=1 and d_rdata=0, next cycle IDLE.
REQ-039 Flush: if_flush pulsed in the 2nd I_BUSY cycle, m_ready at the 4th -> no if_ack and if_rdata unchanged; a pending d_req is granted the next cycle.
REQ-040 Reset mid-operation: rst=0 during D_BUSY -> m_req=0 and no d_ack immediately; after release with if_req=1, the fetch completes normally.
REQ-041 Boundary: m_ready=1 in the same cycle the wait counter hits TIMEOUT -> ack with err=0 and the correct rdata.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one memory port between the instruction fetch
// side and the load/store side. A single transaction is in flight at a time.
// Ties alternate between the two sides, a wait counter aborts stalled
// transactions, and a branch flush discards the in-flight fetch result.
module imem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic       last_d;     // 1: data side was granted last
  logic       kill;       // in-flight fetch was flushed
  logic [7:0] wait_cnt, cnt_inc;
  logic       grant_i, grant_d, tmo, done, fetch_live;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: grant arbitration in IDLE, completion/timeout in busy states
  always_comb begin
    state_nxt  = state;
    cnt_inc    = wait_cnt + 8'd1;
    // m_ready wins over a timeout landing in the same cycle
    tmo        = !m_ready && (cnt_inc == TMO);
    done       = m_ready || tmo;
    grant_i    = (state == IDLE) && if_req && !if_flush && (!d_req || last_d);
    grant_d    = (state == IDLE) && d_req && !grant_i;
    fetch_live = !kill && !if_flush;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = I_BUSY;
        else if (grant_d) state_nxt = D_BUSY;
      end
      I_BUSY, D_BUSY: if (done) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Registered outputs, wait counter, kill flag and tie-break history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_size   <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      wait_cnt <= '0;
      kill     <= 1'b0;
      last_d   <= 1'b1;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          kill     <= 1'b0;
          wait_cnt <= '0;
          if (grant_i) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_size  <= 2'b10;
            m_addr  <= if_addr;
            m_wdata <= '0;
            last_d  <= 1'b0;
          end else if (grant_d) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_size  <= d_size;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            last_d  <= 1'b1;
          end
        end
        I_BUSY: begin
          if (if_flush) kill <= 1'b1;
          if (done) begin
            m_req    <= 1'b0;
            wait_cnt <= '0;
            kill     <= 1'b0;
            // a flushed fetch completes on the bus but is invisible upstream
            if (fetch_live) begin
              if_ack   <= 1'b1;
              if_err   <= tmo;
              if_rdata <= m_ready ? m_rdata : '0;
            end
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        D_BUSY: begin
          if (done) begin
            m_req    <= 1'b0;
            wait_cnt <= '0;
            d_ack    <= 1'b1;
            d_err    <= tmo;
            d_rdata  <= (m_ready && !m_we) ? m_rdata : '0;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: m_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_imem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  imem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step(); step();
    rst = 1;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    idle_inputs();
    rst = 0;
    step(); step();
    outs = {26'd0, if_ack, if_err, d_ack, d_err, m_req, m_we} | if_rdata | d_rdata
         | m_addr | m_wdata | {30'd0, m_size};
    checks++;
    if (outs !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", outs);
    end
    rst = 1;
    step();
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL reset_release_mreq got %b expected 0", m_req);
    end
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    step();
    checks++;
    if ({m_req, m_we, m_size, m_addr, if_ack} !== {1'b1, 1'b0, 2'b10, 32'h100, 1'b0}) begin
      errors++; $display("FAIL fetch_grant got req=%b we=%b size=%b addr=%h ack=%b", m_req, m_we, m_size, m_addr, if_ack);
    end
    m_ready = 1; m_rdata = 32'hDEADBEEF;
    step();
    m_ready = 0; if_req = 0;
    checks++;
    if ({if_ack, if_err, d_ack, m_req, if_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_ack got ack=%b err=%b dack=%b mreq=%b rdata=%h", if_ack, if_err, d_ack, m_req, if_rdata);
    end
    step();
    checks++;
    if ({if_ack, m_req, if_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_hold got ack=%b mreq=%b rdata=%h expected 0 0 deadbeef", if_ack, m_req, if_rdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_addr = 32'h2000; d_we = 1; d_wdata = 32'h55; d_size = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (k % 2 == 0) begin
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h300}) begin
          errors++; $display("FAIL contention_grant%0d got req=%b we=%b addr=%h expected fetch", k, m_req, m_we, m_addr);
        end
      end else begin
        if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h2000, 32'h55}) begin
          errors++; $display("FAIL contention_grant%0d got req=%b we=%b addr=%h wdata=%h expected data", k, m_req, m_we, m_addr, m_wdata);
        end
      end
      m_ready = 1; m_rdata = 32'hA0 + k;
      step();
      m_ready = 0;
      checks++;
      if ({if_ack, d_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contention_ack%0d got if_ack=%b d_ack=%b", k, if_ack, d_ack);
      end
    end
    if_req = 0; d_req = 0;
    step();
  endtask

  task automatic test_boundary();
    bit mreq_ok = 1;
    d_req = 1; d_we = 0; d_addr = 32'h80; d_size = 2'b01;
    step();
    for (int c = 1; c <= TMO; c++) begin
      if (m_req !== 1'b1 || d_ack !== 1'b0) mreq_ok = 0;
      if (c == TMO) begin m_ready = 1; m_rdata = 32'hCAFE1234; end
      step();
    end
    m_ready = 0; d_req = 0;
    checks++;
    if (!mreq_ok) begin
      errors++; $display("FAIL boundary_wait got early drop or ack expected %0d m_req cycles", TMO);
    end
    checks++;
    if ({d_ack, d_err, d_rdata, m_req} !== {1'b1, 1'b0, 32'hCAFE1234, 1'b0}) begin
      errors++; $display("FAIL boundary_ack got ack=%b err=%b rdata=%h mreq=%b expected 1 0 cafe1234 0", d_ack, d_err, d_rdata, m_req);
    end
    step();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit early = 0;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    step();
    for (int i = 0; i < 40 && m_req === 1'b1; i++) begin
      cnt++;
      if (d_ack !== 1'b0) early = 1;
      step();
    end
    d_req = 0;
    checks++;
    if (cnt != TMO || early) begin
      errors++; $display("FAIL timeout_len got %0d m_req cycles (early ack %0d) expected %0d", cnt, early, TMO);
    end
    checks++;
    if ({d_ack, d_err, d_rdata, if_ack} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_ack got ack=%b err=%b rdata=%h if_ack=%b expected 1 1 0 0", d_ack, d_err, d_rdata, if_ack);
    end
    step();
    checks++;
    if ({m_req, d_ack, d_err} !== 3'b000) begin
      errors++; $display("FAIL timeout_idle got mreq=%b ack=%b err=%b expected 000", m_req, d_ack, d_err);
    end
  endtask

  task automatic test_flush();
    bit spurious = 0;
    // establish a known if_rdata
    if_req = 1; if_addr = 32'h400;
    step();
    m_ready = 1; m_rdata = 32'h11112222;
    step();
    m_ready = 0; if_addr = 32'h500;
    // the still-high if_req is granted as a new fetch here (cycle 1 of I_BUSY)
    step();
    checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL flush_grant got mreq=%b addr=%h expected 1 500", m_req, m_addr);
    end
    step();                       // 2nd I_BUSY cycle
    if_flush = 1; if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h6000;
    step();                       // 3rd
    if_flush = 0;
    if (if_ack !== 1'b0) spurious = 1;
    step();                       // 4th
    if (if_ack !== 1'b0) spurious = 1;
    m_ready = 1; m_rdata = 32'h99999999;
    step();
    m_ready = 0;
    checks++;
    if ({if_ack, m_req, if_rdata, d_ack} !== {1'b0, 1'b0, 32'h11112222, 1'b0} || spurious) begin
      errors++; $display("FAIL flush_noack got ack=%b mreq=%b rdata=%h dack=%b expected 0 0 11112222 0", if_ack, m_req, if_rdata, d_ack);
    end
    step();
    checks++;
    if ({m_req, m_addr, if_ack} !== {1'b1, 32'h6000, 1'b0}) begin
      errors++; $display("FAIL flush_dgrant got mreq=%b addr=%h if_ack=%b expected 1 6000 0", m_req, m_addr, if_ack);
    end
    m_ready = 1; m_rdata = 32'h77;
    step();
    m_ready = 0; d_req = 0;
    checks++;
    if ({d_ack, d_rdata, if_ack} !== {1'b1, 32'h77, 1'b0}) begin
      errors++; $display("FAIL flush_dack got ack=%b rdata=%h if_ack=%b expected 1 77 0", d_ack, d_rdata, if_ack);
    end
    step();
  endtask

  task automatic test_flush_idle();
    if_req = 1; if_flush = 1; if_addr = 32'h900;
    step();
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL flush_idle_suppress got mreq=%b expected 0", m_req);
    end
    d_req = 1; d_we = 1; d_addr = 32'hA00; d_wdata = 32'h3;
    step();
    if_req = 0; if_flush = 0;
    checks++;
    if ({m_req, m_we, m_addr} !== {1'b1, 1'b1, 32'hA00}) begin
      errors++; $display("FAIL flush_idle_dgrant got mreq=%b we=%b addr=%h expected 1 1 a00", m_req, m_we, m_addr);
    end
    m_ready = 1; m_rdata = 32'hFFFF;
    step();
    m_ready = 0; d_req = 0;
    checks++;
    if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL write_rdata got ack=%b err=%b rdata=%h expected 1 0 0", d_ack, d_err, d_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    d_req = 1; d_we = 0; d_addr = 32'hB00;
    step();
    step();
    rst = 0;
    #1;
    checks++;
    if ({m_req, d_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_async got mreq=%b dack=%b expected 00", m_req, d_ack);
    end
    m_ready = 1; m_rdata = 32'h5;
    d_req = 0; if_req = 1; if_addr = 32'h700;
    step();
    if (d_ack !== 1'b0 || m_req !== 1'b0) stray = 1;
    m_ready = 0;
    step();
    rst = 1;
    if (d_ack !== 1'b0) stray = 1;
    step();
    checks++;
    if ({m_req, m_addr, d_ack} !== {1'b1, 32'h700, 1'b0} || stray) begin
      errors++; $display("FAIL reset_mid_fetch got mreq=%b addr=%h dack=%b stray=%0d", m_req, m_addr, d_ack, stray);
    end
    m_ready = 1; m_rdata = 32'h1234ABCD;
    step();
    m_ready = 0; if_req = 0;
    checks++;
    if ({if_ack, if_err, if_rdata, d_ack} !== {1'b1, 1'b0, 32'h1234ABCD, 1'b0}) begin
      errors++; $display("FAIL reset_mid_ack got ack=%b err=%b rdata=%h dack=%b", if_ack, if_err, if_rdata, d_ack);
    end
    step();
  endtask

  // Transaction-level model: a grant happens on any edge where the port was
  // free and someone asked; ties go to the side not served last; the memory
  // answers after a random latency, or the transaction aborts after TMO cycles.
  task automatic test_random();
    bit          busy, ended, ready_edge, own_d, last_d, exp_err, t_we;
    int          mcnt, lat, n_tmo, n_done;
    logic [31:0] exp_ird, exp_drd, rd_at_ready, t_addr, t_wdata;
    logic [1:0]  t_size;
    do_reset();
    busy = 0; last_d = 1; own_d = 0; mcnt = 0; lat = 0; t_we = 0;
    exp_ird = 0; exp_drd = 0; rd_at_ready = 0; exp_err = 0;
    t_addr = 0; t_wdata = 0; t_size = 0; n_tmo = 0; n_done = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ready_edge = m_ready;
      step();
      ended = 0;
      if (busy) begin
        if (ready_edge || mcnt == TMO) begin
          ended   = 1;
          exp_err = !ready_edge;
          if (ready_edge) n_done++; else n_tmo++;
          if (own_d) exp_drd = (ready_edge && !t_we) ? rd_at_ready : 32'h0;
          else       exp_ird = ready_edge ? rd_at_ready : 32'h0;
          busy = 0;
        end
      end else if (if_req || d_req) begin
        own_d  = d_req && (!if_req || !last_d);
        last_d = own_d;
        busy   = 1;
        mcnt   = 0;
        lat    = $urandom_range(0, 19);
        t_addr  = own_d ? d_addr : if_addr;
        t_we    = own_d ? d_we : 1'b0;
        t_size  = own_d ? d_size : 2'b10;
        t_wdata = own_d ? d_wdata : 32'h0;
      end
      checks++;
      if (m_req !== busy) begin
        errors++; $display("FAIL rand_mreq cyc %0d got %b expected %b", cyc, m_req, busy);
      end
      if (busy) begin
        checks++;
        if ({m_addr, m_we, m_size, m_wdata} !== {t_addr, t_we, t_size, t_wdata}) begin
          errors++; $display("FAIL rand_fields cyc %0d got %h %b %b %h expected %h %b %b %h", cyc, m_addr, m_we, m_size, m_wdata, t_addr, t_we, t_size, t_wdata);
        end
      end
      checks++;
      if ({if_ack, d_ack} !== {ended && !own_d, ended && own_d} ||
          (ended && ({if_err, d_err} !== {exp_err && !own_d, exp_err && own_d}))) begin
        errors++; $display("FAIL rand_ack cyc %0d got ia=%b ie=%b da=%b de=%b expected end=%b own_d=%b err=%b", cyc, if_ack, if_err, d_ack, d_err, ended, own_d, exp_err);
      end
      checks++;
      if ({if_rdata, d_rdata} !== {exp_ird, exp_drd}) begin
        errors++; $display("FAIL rand_rdata cyc %0d got %h %h expected %h %h", cyc, if_rdata, d_rdata, exp_ird, exp_drd);
      end
      // memory responder
      m_ready = 0;
      if (busy) begin
        mcnt++;
        if (mcnt == lat + 1) begin
          m_ready = 1; m_rdata = $urandom; rd_at_ready = m_rdata;
        end
      end
      // requesters: hold until ack; in the ack cycle, maybe ask again
      if (ended && !own_d) begin
        if ($urandom_range(0, 1) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
        else if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if ((ended && own_d && $urandom_range(0, 1) == 1) || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end else if (ended && own_d) begin
        d_req = 0;
      end
    end
    checks++;
    if (n_tmo == 0 || n_done == 0) begin
      errors++; $display("FAIL rand_coverage got %0d completions %0d timeouts", n_done, n_tmo);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_boundary();
    test_timeout();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
